lsu_mem_arbiter: RTL and testbench
==================================

Name: lsu_mem_arbiter

Overview:
- Shares one data-memory read/write channel pair between NUM_CONSUMERS LSUs of a core.
- Sits between the per-thread LSUs and the data memory.
- Arbitrates round-robin and issues one memory transaction at a time.
- Relays the memory response back to the granted LSU, holding ready until that LSU drops valid.

Parameters:
- NUM_CONSUMERS, 4, number of LSU requesters (>=1).
- ADDR_BITS, 8, memory address width.
- DATA_BITS, 8, memory data width.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- consumer_read_valid  input  NUM_CONSUMERS  per-LSU read request.
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  flattened; slice i = LSU i.
- consumer_read_ready  output  NUM_CONSUMERS  per-LSU read done.
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  per-LSU read data register.
- consumer_write_valid  input  NUM_CONSUMERS  per-LSU write request.
- consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  write address.
- consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  write data.
- consumer_write_ready  output  NUM_CONSUMERS  per-LSU write done.
- mem_read_valid  output  1  memory read request.
- mem_read_address  output  ADDR_BITS  memory read address.
- mem_read_ready  input  1  memory read done; mem_read_data valid in the same cycle.
- mem_read_data  input  DATA_BITS  memory read data.
- mem_write_valid  output  1  memory write request.
- mem_write_address  output  ADDR_BITS  memory write address.
- mem_write_data  output  DATA_BITS  memory write data.
- mem_write_ready  input  1  memory write done.
- busy  output  1  high whenever state != MC_IDLE.

Behaviour:
- Reset (reset==0 at posedge): all outputs 0 (including every consumer_read_data slice); state MC_IDLE; rr_ptr 0. Overrides any in-flight transaction; the abandoned memory request is simply dropped.
- Registers: state, rr_ptr, granted id (width max(1,$clog2(NUM_CONSUMERS))), and all outputs (registered).
- MC_IDLE:
  - Requester i is pending if read_valid[i] | write_valid[i].
  - Winner = first pending index scanning from rr_ptr upward, wrapping modulo NUM_CONSUMERS.
  - If the winner has both read and write valid, read is served first.
  - On a winner: latch id; set rr_ptr <= (id+1) mod NUM_CONSUMERS.
  - Read win: mem_read_valid<=1, mem_read_address<=slice; go to MC_READ_WAIT.
  - Write win: mem_write_valid<=1, mem_write_address and mem_write_data <= slices; go to MC_WRITE_WAIT.
  - No pending requester: stay in MC_IDLE, outputs unchanged.
- MC_READ_WAIT: on mem_read_ready==1: mem_read_valid<=0, consumer_read_data[id]<=mem_read_data, consumer_read_ready[id]<=1; go to MC_READ_RELAY. Otherwise hold.
- MC_WRITE_WAIT: on mem_write_ready==1: mem_write_valid<=0, consumer_write_ready[id]<=1; go to MC_WRITE_RELAY.
- MC_READ_RELAY / MC_WRITE_RELAY: when the granted consumer's matching valid==0: clear its ready; go to MC_IDLE. Ready stays high while valid stays high.
- Consumer address/data are captured at grant only; later changes are ignored.
- Memory ready is ignored outside the WAIT states.
- consumer_read_data slices hold their value until overwritten by a new read to that consumer.
- Consumer drops valid during WAIT (protocol violation): the memory transaction still completes; ready pulses exactly 1 cycle in RELAY.
- Ungranted consumers: ready stays 0, request is held pending and never lost.
- Minimum latency with ready returning 1 cycle after mem valid:
  - grant edge E0;
  - consumer ready high after E1;
  - LSU drops valid at E2;
  - ready low and state MC_IDLE after E3;
  - next grant at E4.
- NUM_CONSUMERS==1: rr_ptr is constant 0.

Decomposition:
- Shared enums header (with LSU_state_t, corestate_t): typedef enum memctrl_state_t {MC_IDLE, MC_READ_WAIT, MC_WRITE_WAIT, MC_READ_RELAY, MC_WRITE_RELAY}.
- Sub-module rr_arbiter (combinational): inputs request vector and rr_ptr; outputs found flag and winner index.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-transaction -> all outputs 0, busy=0, state MC_IDLE, rr_ptr 0.
- Single read: LSU1 reads addr 0x12, memory returns 0xAB one cycle after mem_read_valid -> mem_read_address=0x12; consumer_read_data[1]=0xAB with consumer_read_ready[1] high until LSU1 drops valid; back to MC_IDLE after 4 edges.
- Single write: LSU2 writes 0x55 to 0x30, memory ready after 3 cycles -> mem_write_address=0x30, mem_write_data=0x55; consumer_write_ready[2] pulses; no read activity.
- Round-robin: LSUs 0-3 all request reads together -> grants in order 0,1,2,3. LSU0 re-requests after completion -> LSU0 is served only after 3, with no starvation.
- Mixed same-consumer: LSU0 asserts read and write together -> read served first, write next. Other LSUs' slices remain untouched.
- Violation and stall: LSU3 drops valid during MC_READ_WAIT, memory ready stalled 10 cycles -> mem_read_valid stays high 10 cycles; consumer_read_ready[3] high exactly 1 cycle; returns to MC_IDLE.

Source files
------------

// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types for the LSU/memory path: controller, LSU and core state encodings.
package lsu_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    MC_IDLE,
    MC_READ_WAIT,
    MC_WRITE_WAIT,
    MC_READ_RELAY,
    MC_WRITE_RELAY
  } memctrl_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQUESTING,
    LSU_WAITING,
    LSU_DONE
  } LSU_state_t;

  typedef enum logic [2:0] {
    CORE_IDLE,
    CORE_FETCH,
    CORE_DECODE,
    CORE_REQUEST,
    CORE_WAIT,
    CORE_EXECUTE,
    CORE_UPDATE,
    CORE_DONE
  } corestate_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/lsu_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first pending requester at or above rr_ptr, wrapping.
module lsu_mem_arbiter_rr_arbiter
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned ID_W          = id_width(NUM_CONSUMERS)
) (
  input  logic [NUM_CONSUMERS-1:0] request,
  input  logic [ID_W-1:0]          rr_ptr,
  output logic                     found_c,
  output logic [ID_W-1:0]          winner_c
);

  logic found_hi_c;
  logic found_lo_c;
  logic [ID_W-1:0] winner_hi_c;
  logic [ID_W-1:0] winner_lo_c;

  // Two ascending scans: indices >= rr_ptr take priority over the wrapped ones.
  always_comb begin
    found_hi_c  = 1'b0;
    found_lo_c  = 1'b0;
    winner_hi_c = '0;
    winner_lo_c = '0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      if (request[i] && (i >= 32'(rr_ptr)) && !found_hi_c) begin
        found_hi_c  = 1'b1;
        winner_hi_c = ID_W'(i);
      end
      if (request[i] && (i < 32'(rr_ptr)) && !found_lo_c) begin
        found_lo_c  = 1'b1;
        winner_lo_c = ID_W'(i);
      end
    end
  end

  assign found_c  = found_hi_c | found_lo_c;
  assign winner_c = found_hi_c ? winner_hi_c : winner_lo_c;

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory read/write channel pair among the LSUs of a core.
// One transaction at a time, granted round-robin; response held until the LSU drops valid.
module lsu_mem_arbiter
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready,
  output logic                               busy
);

  localparam int unsigned ID_W = id_width(NUM_CONSUMERS);

  memctrl_state_t state;
  memctrl_state_t state_nxt;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_ptr_nxt;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] gnt_id_nxt;

  logic [NUM_CONSUMERS-1:0] pending_c;
  logic                     found_c;
  logic [ID_W-1:0]          winner_c;
  logic                     win_is_read_c;

  logic [ADDR_BITS-1:0] rd_addr_a [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0] wr_addr_a [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] wr_data_a [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rd_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rd_data_nxt [NUM_CONSUMERS];

  logic                     mem_read_valid_nxt;
  logic [ADDR_BITS-1:0]     mem_read_address_nxt;
  logic                     mem_write_valid_nxt;
  logic [ADDR_BITS-1:0]     mem_write_address_nxt;
  logic [DATA_BITS-1:0]     mem_write_data_nxt;
  logic [NUM_CONSUMERS-1:0] read_ready_nxt;
  logic [NUM_CONSUMERS-1:0] write_ready_nxt;
  logic                     busy_nxt;

  // Per-consumer views of the flattened buses.
  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_slice
    assign rd_addr_a[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_addr_a[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_data_a[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = rd_data_q[g];
  end

  assign pending_c = consumer_read_valid | consumer_write_valid;

  lsu_mem_arbiter_rr_arbiter #(
    .NUM_CONSUMERS(NUM_CONSUMERS),
    .ID_W         (ID_W)
  ) u_rr_arbiter (
    .request (pending_c),
    .rr_ptr  (rr_ptr),
    .found_c (found_c),
    .winner_c(winner_c)
  );

  // A winner with both requests raised is served as a read first.
  assign win_is_read_c = consumer_read_valid[winner_c];

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= MC_IDLE;
      rr_ptr               <= '0;
      gnt_id               <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      busy                 <= 1'b0;
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
        rd_data_q[i] <= '0;
      end
    end else begin
      state                <= state_nxt;
      rr_ptr               <= rr_ptr_nxt;
      gnt_id               <= gnt_id_nxt;
      mem_read_valid       <= mem_read_valid_nxt;
      mem_read_address     <= mem_read_address_nxt;
      mem_write_valid      <= mem_write_valid_nxt;
      mem_write_address    <= mem_write_address_nxt;
      mem_write_data       <= mem_write_data_nxt;
      consumer_read_ready  <= read_ready_nxt;
      consumer_write_ready <= write_ready_nxt;
      busy                 <= busy_nxt;
      rd_data_q            <= rd_data_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      MC_IDLE: begin
        if (found_c) begin
          state_nxt = win_is_read_c ? MC_READ_WAIT : MC_WRITE_WAIT;
        end
      end
      MC_READ_WAIT: begin
        if (mem_read_ready) begin
          state_nxt = MC_READ_RELAY;
        end
      end
      MC_WRITE_WAIT: begin
        if (mem_write_ready) begin
          state_nxt = MC_WRITE_RELAY;
        end
      end
      MC_READ_RELAY: begin
        if (!consumer_read_valid[gnt_id]) begin
          state_nxt = MC_IDLE;
        end
      end
      MC_WRITE_RELAY: begin
        if (!consumer_write_valid[gnt_id]) begin
          state_nxt = MC_IDLE;
        end
      end
      default: state_nxt = MC_IDLE;
    endcase
  end

  // Output and datapath next values; everything holds unless a transition updates it.
  always_comb begin
    rr_ptr_nxt            = rr_ptr;
    gnt_id_nxt            = gnt_id;
    mem_read_valid_nxt    = mem_read_valid;
    mem_read_address_nxt  = mem_read_address;
    mem_write_valid_nxt   = mem_write_valid;
    mem_write_address_nxt = mem_write_address;
    mem_write_data_nxt    = mem_write_data;
    read_ready_nxt        = consumer_read_ready;
    write_ready_nxt       = consumer_write_ready;
    rd_data_nxt           = rd_data_q;
    busy_nxt              = (state_nxt != MC_IDLE);
    case (state)
      MC_IDLE: begin
        if (found_c) begin
          gnt_id_nxt = winner_c;
          rr_ptr_nxt = (32'(winner_c) == NUM_CONSUMERS - 1) ? '0 : ID_W'(32'(winner_c) + 1);
          if (win_is_read_c) begin
            mem_read_valid_nxt   = 1'b1;
            mem_read_address_nxt = rd_addr_a[winner_c];
          end else begin
            mem_write_valid_nxt   = 1'b1;
            mem_write_address_nxt = wr_addr_a[winner_c];
            mem_write_data_nxt    = wr_data_a[winner_c];
          end
        end
      end
      MC_READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_nxt     = 1'b0;
          rd_data_nxt[gnt_id]    = mem_read_data;
          read_ready_nxt[gnt_id] = 1'b1;
        end
      end
      MC_WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_nxt     = 1'b0;
          write_ready_nxt[gnt_id] = 1'b1;
        end
      end
      MC_READ_RELAY: begin
        if (!consumer_read_valid[gnt_id]) begin
          read_ready_nxt[gnt_id] = 1'b0;
        end
      end
      MC_WRITE_RELAY: begin
        if (!consumer_write_valid[gnt_id]) begin
          write_ready_nxt[gnt_id] = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Scoreboard bench for lsu_mem_arbiter: directed requests, expected events queued, monitor compares.
module tb_lsu_mem_arbiter;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] rd_valid, rd_ready, wr_valid, wr_ready;
  logic [NC*AW-1:0] rd_addr, wr_addr;
  logic [NC*DW-1:0] rd_data, wr_data;
  logic          mem_rv, mem_rr, mem_wv, mem_wr;
  logic [AW-1:0] mem_ra, mem_wa;
  logic [DW-1:0] mem_rd, mem_wd;
  logic          busy;

  lsu_mem_arbiter #(.NUM_CONSUMERS(NC), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (rd_valid),
    .consumer_read_address (rd_addr),
    .consumer_read_ready   (rd_ready),
    .consumer_read_data    (rd_data),
    .consumer_write_valid  (wr_valid),
    .consumer_write_address(wr_addr),
    .consumer_write_data   (wr_data),
    .consumer_write_ready  (wr_ready),
    .mem_read_valid        (mem_rv),
    .mem_read_address      (mem_ra),
    .mem_read_ready        (mem_rr),
    .mem_read_data         (mem_rd),
    .mem_write_valid       (mem_wv),
    .mem_write_address     (mem_wa),
    .mem_write_data        (mem_wd),
    .mem_write_ready       (mem_wr),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [7:0]  data;
    int          lat;
  } mem_exp_t;

  typedef struct {
    bit          is_wr;
    int          id;
    logic [7:0]  data;
    int          rdy_len;
    int          busy_len;
  } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem_model [256];
  int rd_lat, wr_lat, rcnt, wcnt;
  logic [NC-1:0] seen_rd, seen_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One cycle: memory responder and registered-LSU release behaviour, at the falling edge.
  task automatic step();
    @(negedge clk);
    if (!reset) begin
      mem_rr = 1'b0; mem_wr = 1'b0; rcnt = 0; wcnt = 0;
      seen_rd = '0; seen_wr = '0;
    end else begin
      if (mem_rr) begin
        mem_rr = 1'b0; rcnt = 0;
      end else if (mem_rv) begin
        rcnt++;
        if (rcnt >= rd_lat) begin mem_rr = 1'b1; mem_rd = mem_model[mem_ra]; end
      end
      if (mem_wr) begin
        mem_wr = 1'b0; wcnt = 0;
      end else if (mem_wv) begin
        wcnt++;
        if (wcnt >= wr_lat) begin mem_wr = 1'b1; mem_model[mem_wa] = mem_wd; end
      end
      for (int i = 0; i < NC; i++) begin
        if (seen_rd[i]) begin rd_valid[i] = 1'b0; seen_rd[i] = 1'b0; end
        else if (rd_ready[i] && rd_valid[i]) seen_rd[i] = 1'b1;
        if (seen_wr[i]) begin wr_valid[i] = 1'b0; seen_wr[i] = 1'b0; end
        else if (wr_ready[i] && wr_valid[i]) seen_wr[i] = 1'b1;
      end
    end
  endtask

  task automatic issue_read(input int id, input logic [7:0] a, input logic [7:0] d,
                            input int lat, input int rlen, input int blen);
    rd_addr[id*AW +: AW] = a;
    rd_valid[id] = 1'b1;
    mem_q.push_back('{is_wr: 1'b0, addr: a, data: 8'h00, lat: lat});
    rsp_q.push_back('{is_wr: 1'b0, id: id, data: d, rdy_len: rlen, busy_len: blen});
  endtask

  task automatic issue_write(input int id, input logic [7:0] a, input logic [7:0] d,
                             input int lat, input int rlen, input int blen);
    wr_addr[id*AW +: AW] = a;
    wr_data[id*DW +: DW] = d;
    wr_valid[id] = 1'b1;
    mem_q.push_back('{is_wr: 1'b1, addr: a, data: d, lat: lat});
    rsp_q.push_back('{is_wr: 1'b1, id: id, data: 8'h00, rdy_len: rlen, busy_len: blen});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    step();
    while ((busy || rd_valid != '0 || wr_valid != '0) && n < 300) begin
      step();
      n++;
    end
    check(name, 64'({busy, rd_valid, wr_valid}), 64'(0));
  endtask

  // Monitor: compares DUT activity against the queued expectations.
  initial begin
    logic [NC-1:0]    prv_rr = '0, prv_wr = '0;
    logic             prv_mrv = 1'b0, prv_mwv = 1'b0, prv_busy = 1'b0;
    int               mrv_len = 0, mwv_len = 0, rdy_len = 0, busy_len = 0;
    mem_exp_t         cur_rm, cur_wm;
    rsp_exp_t         cur_rsp;
    bit               rm_act = 0, wm_act = 0, rsp_act = 0;
    logic [7:0]       exp_slice [NC];
    logic [NC*DW-1:0] exp_pack;
    logic [2*NC-1:0]  exp_rdy;
    logic             r;
    for (int i = 0; i < NC; i++) exp_slice[i] = 8'h00;
    forever begin
      @(posedge clk);
      r = reset;
      @(negedge clk);
      if (!r) begin
        check("reset_ctrl", 64'({rd_ready, wr_ready, mem_rv, mem_wv, busy}), 64'(0));
        check("reset_data", 64'({rd_data, mem_ra, mem_wa, mem_wd}), 64'(0));
        for (int i = 0; i < NC; i++) exp_slice[i] = 8'h00;
        prv_rr = '0; prv_wr = '0; prv_mrv = 1'b0; prv_mwv = 1'b0; prv_busy = 1'b0;
        rm_act = 0; wm_act = 0; rsp_act = 0;
      end else begin
        if (mem_rv && !prv_mrv) begin
          check("mem_rd_expected", 64'(mem_q.size() > 0), 64'(1));
          if (mem_q.size() > 0) begin
            cur_rm = mem_q.pop_front();
            rm_act = 1;
            mrv_len = 0;
            check("mem_rd_kind", 64'(cur_rm.is_wr), 64'(0));
            check("mem_rd_addr", 64'(mem_ra), 64'(cur_rm.addr));
          end
        end
        if (mem_wv && !prv_mwv) begin
          check("mem_wr_expected", 64'(mem_q.size() > 0), 64'(1));
          if (mem_q.size() > 0) begin
            cur_wm = mem_q.pop_front();
            wm_act = 1;
            mwv_len = 0;
            check("mem_wr_kind", 64'(cur_wm.is_wr), 64'(1));
            check("mem_wr_addr_data", 64'({mem_wa, mem_wd}), 64'({cur_wm.addr, cur_wm.data}));
          end
        end
        if (mem_rv) mrv_len++;
        if (mem_wv) mwv_len++;
        if (!mem_rv && prv_mrv && rm_act) begin
          check("mem_rd_valid_cycles", 64'(mrv_len), 64'(cur_rm.lat));
          rm_act = 0;
        end
        if (!mem_wv && prv_mwv && wm_act) begin
          check("mem_wr_valid_cycles", 64'(mwv_len), 64'(cur_wm.lat));
          wm_act = 0;
        end

        if (((rd_ready & ~prv_rr) | (wr_ready & ~prv_wr)) != '0) begin
          check("rsp_expected", 64'(rsp_q.size() > 0), 64'(1));
          if (rsp_q.size() > 0) begin
            cur_rsp = rsp_q.pop_front();
            rsp_act = 1;
            rdy_len = 0;
            exp_rdy = '0;
            if (cur_rsp.is_wr) exp_rdy[cur_rsp.id] = 1'b1;
            else exp_rdy[NC + cur_rsp.id] = 1'b1;
            check("ready_onehot", 64'({rd_ready, wr_ready}), 64'(exp_rdy));
            if (!cur_rsp.is_wr) begin
              exp_slice[cur_rsp.id] = cur_rsp.data;
              for (int i = 0; i < NC; i++) exp_pack[i*DW +: DW] = exp_slice[i];
              check("read_data_slices", 64'(rd_data), 64'(exp_pack));
            end
          end
        end
        if ({rd_ready, wr_ready} != '0) rdy_len++;
        if ({rd_ready, wr_ready} == '0 && {prv_rr, prv_wr} != '0 && rsp_act) begin
          check("ready_cycles", 64'(rdy_len), 64'(cur_rsp.rdy_len));
        end
        if (busy && !prv_busy) busy_len = 0;
        if (busy) busy_len++;
        if (!busy && prv_busy && rsp_act) begin
          check("busy_cycles", 64'(busy_len), 64'(cur_rsp.busy_len));
          rsp_act = 0;
        end
        prv_rr = rd_ready; prv_wr = wr_ready;
        prv_mrv = mem_rv; prv_mwv = mem_wv; prv_busy = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected below 200000", $time);
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    for (int a = 0; a < 256; a++) mem_model[a] = 8'h00;
    mem_model[8'h12] = 8'hAB;
    mem_model[8'h21] = 8'h5C;
    mem_model[8'h23] = 8'hE7;
    mem_model[8'h40] = 8'hC0;
    mem_model[8'h41] = 8'hC1;
    mem_model[8'h42] = 8'hC2;
    mem_model[8'h43] = 8'hC3;
    mem_model[8'h44] = 8'hC4;
    mem_model[8'h60] = 8'h9C;
    mem_model[8'h70] = 8'h3E;
    reset = 1'b0;
    rd_valid = '0; wr_valid = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    mem_rr = 1'b0; mem_wr = 1'b0; mem_rd = '0;
    rd_lat = 1; wr_lat = 1; rcnt = 0; wcnt = 0;
    seen_rd = '0; seen_wr = '0;
    step(); step();
    reset = 1'b1;
    step();

    // Single read: LSU1 @0x12 -> 0xAB, memory answers one cycle after the request.
    rd_lat = 1;
    issue_read(1, 8'h12, 8'hAB, 1, 2, 3);
    wait_idle("idle_after_single_read");

    // Single write: LSU2 writes 0x55 @0x30, memory ready after 3 cycles.
    wr_lat = 3;
    issue_write(2, 8'h30, 8'h55, 3, 2, 5);
    wait_idle("idle_after_single_write");
    check("mem_model_written", 64'(mem_model[8'h30]), 64'(8'h55));

    // Reset in the middle of a stalled LSU2 read; request dropped, rr_ptr back to 0.
    rd_lat = 50;
    rd_addr[2*AW +: AW] = 8'h20;
    rd_valid[2] = 1'b1;
    mem_q.push_back('{is_wr: 1'b0, addr: 8'h20, data: 8'h00, lat: 50});
    step(); step(); step(); step();
    rd_valid = '0;
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    rd_lat = 1;
    issue_read(0, 8'h21, 8'h5C, 1, 2, 3);
    issue_read(3, 8'h23, 8'hE7, 1, 2, 3);
    wait_idle("idle_after_reset_pair");

    // Round-robin: all four read at once; LSU0 re-requests and must wait behind LSU3.
    issue_read(0, 8'h40, 8'hC0, 1, 2, 3);
    issue_read(1, 8'h41, 8'hC1, 1, 2, 3);
    issue_read(2, 8'h42, 8'hC2, 1, 2, 3);
    issue_read(3, 8'h43, 8'hC3, 1, 2, 3);
    for (int n = 0; n < 100; n++) begin
      step();
      if (!rd_valid[0] && !rd_ready[0]) break;
    end
    issue_read(0, 8'h44, 8'hC4, 1, 2, 3);
    wait_idle("idle_after_round_robin");

    // Same consumer read+write: read first, then write; other slices untouched.
    issue_read(0, 8'h60, 8'h9C, 1, 2, 3);
    wr_lat = 1;
    issue_write(0, 8'h50, 8'h77, 1, 2, 3);
    wait_idle("idle_after_mixed");

    // LSU3 drops valid while memory stalls 10 cycles: ready pulses for one cycle.
    rd_lat = 10;
    issue_read(3, 8'h70, 8'h3E, 10, 1, 11);
    step(); step();
    rd_valid[3] = 1'b0;
    wait_idle("idle_after_violation");

    step(); step();
    check("mem_q_drained", 64'(mem_q.size()), 64'(0));
    check("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
